// File: rtl/mdiv_pkg.sv
// Shared constants and state encoding for the multiply/divide unit.
package mdiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam logic [WIDTH-1:0] OVF_VALUE = 32'h8000_0000;

    // Magnitude of a two's-complement operand; the most negative value maps to unsigned 2^31.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        if (x == OVF_VALUE) begin
            return OVF_VALUE;
        end
        return x[WIDTH-1] ? WIDTH'(-x) : x;
    endfunction

endpackage

// File: rtl/iterative_divider_if.sv
// Start/ready handshake and operand/result bus shared with the multiplier.
interface iterative_divider_if;
    import mdiv_pkg::*;

    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/div_sub33.sv
// 33-bit subtractor a - b built as a generate/propagate adder with b inverted and carry-in 1.
module div_sub33
    import mdiv_pkg::*;
(
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           nonneg
);

    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   p;
    logic [WIDTH:0]   c;

    always_comb begin
        g    = a[WIDTH-1:0] & ~b[WIDTH-1:0];
        p    = a ^ ~b;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        diff   = p ^ c;
        nonneg = ~diff[WIDTH];
    end

endmodule

// File: rtl/iterative_divider.sv
// Restoring signed divider: one quotient bit per cycle, sign fixed up on the way out.
module iterative_divider
    import mdiv_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    iterative_divider_if.slave  bus
);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] abs_b;
    logic             sign_q;
    logic             divzero;

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quot_sh;
    logic [WIDTH:0]   trial;
    logic             trial_ok;

    // The dividend bits stream out of quot into the remainder as quotient bits stream in.
    always_comb begin
        shifted = {rem, quot} << 1;
        rem_sh  = shifted[2*WIDTH:WIDTH];
        quot_sh = shifted[WIDTH-1:0];
    end

    div_sub33 u_sub (
        .a      (rem_sh),
        .b      ({1'b0, abs_b}),
        .diff   (trial),
        .nonneg (trial_ok)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            rem                <= '0;
            quot               <= '0;
            abs_b              <= '0;
            sign_q             <= 1'b0;
            divzero            <= 1'b0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            bus.data_resultRDY <= 1'b0;
            bus.data_exception <= 1'b0;

            // The result of a finishing division is published even if a new start arrives now.
            if (state == DONE) begin
                bus.data_result    <= divzero ? '0 : (sign_q ? WIDTH'(-quot) : quot);
                bus.data_exception <= divzero;
                bus.data_resultRDY <= 1'b1;
            end

            if (bus.ctrl_DIV) begin
                quot     <= abs_val(bus.data_operandA);
                abs_b    <= abs_val(bus.data_operandB);
                sign_q   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                divzero  <= (bus.data_operandB == '0);
                rem      <= '0;
                cnt      <= '0;
                state    <= RUN;
                bus.busy <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        bus.busy <= 1'b0;
                    end
                    RUN: begin
                        rem  <= trial_ok ? trial : rem_sh;
                        quot <= {quot_sh[WIDTH-1:1], trial_ok};
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ITER - 1)) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Randomised and directed checks of the iterative divider against a plain-arithmetic model.
module tb_iterative_divider;

    logic clock;
    logic reset;

    iterative_divider_if bus ();

    iterative_divider dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) return 32'h0;
        q = sa / sb;
        return 32'(q);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs one division from a start pulse; returns latency, busy history and the following cycle.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_ok,
                          output logic [31:0] res, output logic exc,
                          output logic rdy_next, output logic exc_next,
                          output logic busy_next, output logic [31:0] res_next);
        int k;
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        step();
        bus.ctrl_DIV = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        res = '0;
        exc = 1'b0;
        k = 0;
        while (lat < 0 && k <= 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.data_resultRDY === 1'b1) begin
                lat = k;
                res = bus.data_result;
                exc = bus.data_exception;
            end else begin
                step();
                k++;
            end
        end
        step();
        rdy_next  = bus.data_resultRDY;
        exc_next  = bus.data_exception;
        busy_next = bus.busy;
        res_next  = bus.data_result;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        step();
        step();
        vectors++;
        if (bus.data_result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_result: got %h expected %h", bus.data_result, 32'h0);
        end
        vectors++;
        if (bus.data_exception !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_exception: got %b expected 0", bus.data_exception);
        end
        vectors++;
        if (bus.data_resultRDY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_signed_cases();
        logic [31:0] ta [9] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'd5,
                                32'd0, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tb [9] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0,
                                32'd5, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF};
        int lat;
        logic busy_ok, exc, rdy_n, exc_n, busy_n;
        logic [31:0] res, res_n, exp_q;
        logic exp_e;
        for (int i = 0; i < 9; i++) begin
            do_div(ta[i], tb[i], lat, busy_ok, res, exc, rdy_n, exc_n, busy_n, res_n);
            exp_q = ref_quot(ta[i], tb[i]);
            exp_e = (tb[i] == 32'h0);
            vectors++;
            if (lat !== 33) begin
                miscompares++;
                $display("FAIL case%0d_latency: got %0d expected 33 edges after start", i, lat);
            end
            vectors++;
            if (busy_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL case%0d_busy_during: got %b expected 1", i, busy_ok);
            end
            vectors++;
            if (res !== exp_q) begin
                miscompares++;
                $display("FAIL case%0d_result %h/%h: got %h expected %h", i, ta[i], tb[i], res, exp_q);
            end
            vectors++;
            if (exc !== exp_e) begin
                miscompares++;
                $display("FAIL case%0d_exception: got %b expected %b", i, exc, exp_e);
            end
            vectors++;
            if (rdy_n !== 1'b0 || exc_n !== 1'b0 || busy_n !== 1'b0) begin
                miscompares++;
                $display("FAIL case%0d_after_rdy: got rdy=%b exc=%b busy=%b expected all 0",
                         i, rdy_n, exc_n, busy_n);
            end
            vectors++;
            if (res_n !== exp_q) begin
                miscompares++;
                $display("FAIL case%0d_result_hold: got %h expected %h", i, res_n, exp_q);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic busy_ok, exc, rdy_n, exc_n, busy_n;
        logic [31:0] res, res_n, a, b, exp_q;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 15));
                2: b = 32'(-$signed(32'($urandom_range(1, 300))));
                default: b = {16'h0, 16'($urandom)};
            endcase
            do_div(a, b, lat, busy_ok, res, exc, rdy_n, exc_n, busy_n, res_n);
            exp_q = ref_quot(a, b);
            vectors++;
            if (lat !== 33 || busy_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL rand%0d_timing: got lat=%0d busy_ok=%b expected 33/1", i, lat, busy_ok);
            end
            vectors++;
            if (res !== exp_q || exc !== (b == 32'h0)) begin
                miscompares++;
                $display("FAIL rand%0d_result %h/%h: got %h exc=%b expected %h exc=%b",
                         i, a, b, res, exc, exp_q, (b == 32'h0));
            end
        end
    endtask

    task automatic test_restart();
        int lat;
        logic busy_ok, exc, rdy_n, exc_n, busy_n, rdy_seen;
        logic [31:0] res, res_n;
        bus.ctrl_DIV = 1'b1;
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
        step();
        bus.ctrl_DIV = 1'b0;
        rdy_seen = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (bus.data_resultRDY === 1'b1) rdy_seen = 1'b1;
        end
        do_div(32'd81, 32'd9, lat, busy_ok, res, exc, rdy_n, exc_n, busy_n, res_n);
        vectors++;
        if (rdy_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_no_early_rdy: got %b expected 0", rdy_seen);
        end
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("FAIL restart_latency: got %0d expected 33", lat);
        end
        vectors++;
        if (res !== 32'd9 || exc !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_result: got %h exc=%b expected %h exc=0", res, exc, 32'd9);
        end
    endtask

    task automatic test_start_in_done();
        int lat;
        logic rdy_early;
        logic [31:0] res, exp_q;
        bus.ctrl_DIV = 1'b1;
        bus.data_operandA = 32'd1000;
        bus.data_operandB = 32'd10;
        step();
        bus.ctrl_DIV = 1'b0;
        rdy_early = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (bus.data_resultRDY === 1'b1) rdy_early = 1'b1;
        end
        bus.ctrl_DIV = 1'b1;
        bus.data_operandA = 32'hFFFF_FFAF;
        bus.data_operandB = 32'd9;
        step();
        bus.ctrl_DIV = 1'b0;
        vectors++;
        if (rdy_early !== 1'b0) begin
            miscompares++;
            $display("FAIL done_start_early_rdy: got %b expected 0", rdy_early);
        end
        vectors++;
        if (bus.data_resultRDY !== 1'b1 || bus.data_result !== 32'd100 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL done_start_old_result: got rdy=%b res=%h busy=%b expected 1/%h/1",
                     bus.data_resultRDY, bus.data_result, bus.busy, 32'd100);
        end
        lat = -1;
        res = '0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (lat < 0 && bus.data_resultRDY === 1'b1) begin
                lat = k;
                res = bus.data_result;
            end
        end
        exp_q = ref_quot(32'hFFFF_FFAF, 32'd9);
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("FAIL done_start_latency: got %0d expected 33", lat);
        end
        vectors++;
        if (res !== exp_q) begin
            miscompares++;
            $display("FAIL done_start_new_result: got %h expected %h", res, exp_q);
        end
    endtask

    task automatic test_reset_midop();
        int lat, rdy_count, busy_count;
        logic busy_ok, exc, rdy_n, exc_n, busy_n;
        logic [31:0] res, res_n;
        bus.ctrl_DIV = 1'b1;
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
        step();
        bus.ctrl_DIV = 1'b0;
        for (int k = 1; k <= 14; k++) step();
        reset = 1'b1;
        step();
        vectors++;
        if (bus.data_result !== 32'h0 || bus.data_exception !== 1'b0 ||
            bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset_outputs: got res=%h exc=%b rdy=%b busy=%b expected all 0",
                     bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
        end
        reset = 1'b0;
        rdy_count = 0;
        busy_count = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.data_resultRDY === 1'b1) rdy_count++;
            if (bus.busy !== 1'b0) busy_count++;
        end
        vectors++;
        if (rdy_count !== 0 || busy_count !== 0) begin
            miscompares++;
            $display("FAIL midop_no_rdy: got rdy=%0d busy=%0d cycles expected 0/0", rdy_count, busy_count);
        end
        do_div(32'd64, 32'd8, lat, busy_ok, res, exc, rdy_n, exc_n, busy_n, res_n);
        vectors++;
        if (lat !== 33 || res !== 32'd8 || exc !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_next_div: got lat=%0d res=%h exc=%b expected 33/%h/0", lat, res, exc, 32'd8);
        end
    endtask

    initial begin
        test_reset();
        test_signed_cases();
        test_random();
        test_restart();
        test_start_in_done();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
